// File: rtl/ss_downcounter6.sv
// ss_downcounter6 -- loadable down-counter / timer.
//
// A load (jmp) sets the count and the reload value. Each advance pulse (adv)
// in RUN takes one off the count. When the count passes 1 -> 0 a one-cycle
// terminal-count pulse (tc) is raised. In one-shot mode the counter then
// parks in DONE at zero. In periodic mode it reloads and keeps running, which
// makes it a divide-by-N event source.
//
// Optional build feature: define SSDOWN_BORROW_OUT_EN to add the
// combinational look-ahead output bo. bo is high in the cycle before tc and
// is meant to drive the adv input of an upper cascade stage.
module ss_downcounter6 #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             jmp,
  input  logic             per,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy,
  output logic             zero
`ifdef SSDOWN_BORROW_OUT_EN
  ,
  output logic             bo
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             per_q, per_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  // State register. rst wins over every other request, even in mid-count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      out_q    <= CNT_ZERO;
      reload_q <= CNT_ZERO;
      per_q    <= 1'b0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples its pre-edge value and simulation order cannot
      // change the result.
      state_q  <= state_d;
      out_q    <= out_d;
      reload_q <= reload_d;
      per_q    <= per_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic. A load beats an advance, and only RUN reacts to adv.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d  = state_q;
    out_d    = out_q;
    reload_d = reload_q;
    per_d    = per_q;
    tc_d     = 1'b0;

    if (jmp) begin
      out_d    = in;
      reload_d = in;
      per_d    = per;
      state_d  = (in != CNT_ZERO) ? S_RUN : S_DONE;
    end else if ((state_q == S_RUN) && adv) begin
      if (out_q == CNT_ONE) begin
        tc_d = 1'b1;
        if (per_q) begin
          out_d = reload_q;
        end else begin
          out_d   = CNT_ZERO;
          state_d = S_DONE;
        end
      end else begin
        // out_q is always >= 2 here, because RUN never holds zero.
        out_d = out_q - CNT_ONE;
      end
    end

    busy_d = (state_d == S_RUN);
  end

  assign out  = out_q;
  assign tc   = tc_q;
  assign busy = busy_q;
  assign zero = (out_q == CNT_ZERO);

`ifdef SSDOWN_BORROW_OUT_EN
  // Same-cycle look-ahead of tc, used as the cascade carry.
  assign bo = (state_q == S_RUN) && adv && (out_q == CNT_ONE) && !jmp && !rst;
`endif

endmodule

// File: doc/ss_downcounter6.md
Name: ss_downcounter6

Overview:
- Loadable down-counter/timer; the counting-down counterpart of the team's loadable up-counter, with the same adv/jmp/in control style.
- Counts a loaded value down to zero on advance pulses and flags terminal count.
- Runs one-shot or periodic; periodic reload makes it a programmable divide-by-N event source.
- Sits between a control FSM (which loads and advances it) and downstream logic that consumes the terminal-count pulses.

Parameters:
- WIDTH, 6, counter and load-value width in bits; must be >= 2.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous reset, active-high; sampled on the rising edge of clk.
- adv  input  1  decrement request; one decrement per clock cycle while asserted in RUN.
- jmp  input  1  load request; loads in into out and into the reload register.
- per  input  1  mode select, sampled only when jmp=1: 1 = periodic, 0 = one-shot.
- in  input  WIDTH  load value N.
- out  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse (registered, one cycle wide).
- busy  output  1  1 while state is RUN (registered).
- zero  output  1  1 when out==0 (combinational decode of out).

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; out=0, tc=0, busy=0, reload register=0, mode=one-shot.
  - zero therefore reads 1.
  - rst overrides jmp and adv, including mid-count.
- States are IDLE, RUN and DONE. In every state and every cycle, tc defaults to 0 unless a rule below sets it.
- Priority: rst > jmp > adv.
- jmp=1, from any state, next cycle:
  - out=in, reload register=in, mode=per.
  - If in!=0: state=RUN.
  - If in==0: state=DONE, tc stays 0.
  - A jmp in the same cycle as a terminal count suppresses that tc.
- IDLE and DONE: adv is ignored; out holds its value.
- RUN with adv=1 and out>1: out=out-1, no tc.
- RUN with adv=1 and out==1:
  - tc=1 on the next cycle.
  - One-shot mode: out=0, state=DONE.
  - Periodic mode: out=reload value, state stays RUN.
- RUN with adv=0: everything holds.
- Timing consequences:
  - The period is exactly N adv pulses; idle cycles between pulses do not count.
  - Back-to-back tc pulses are possible when N=1 and adv is held high in periodic mode.
- out never wraps below 0. The WIDTH-bit arithmetic never underflows because out==0 is never decremented.
- busy=1 exactly while the state is RUN.

Optional Feature:
- Macro SSDOWN_BORROW_OUT_EN.
- When defined, adds output port bo (1 bit, combinational): bo = (state==RUN) && adv && (out==1) && !jmp && !rst.
  - bo is the same-cycle look-ahead of tc, used to cascade an upper counter stage as its adv.
- When not defined: the port bo does not exist and no logic is generated for it.
- All other behaviour is identical in both builds.

Test Plan:
- Reset and IDLE: rst=1 for 2 cycles, then adv=1 for 5 cycles → out=0, zero=1, busy=0, tc never asserted.
- One-shot count: jmp with in=3, per=0, then adv=1 for 5 cycles.
  - out sequence 3,2,1,0,0.
  - tc=1 for exactly one cycle, coincident with out first reading 0.
  - busy falls at that same cycle; out holds 0 after.
- Periodic divide with gaps: jmp with in=4, per=1, then adv toggling 1,0,1,0,… for 16 cycles → tc every 4th adv pulse (2 pulses total); out returns to 4 after each tc.
- Priority and abort:
  - jmp with in=5 while in RUN with out=1 and adv=1 → out=5 next cycle, no tc.
  - rst=1 mid-count (out=2) → out=0, state IDLE, tc=0.
- Zero load, N=1, and max value:
  - jmp with in=0 → DONE, zero=1, no tc.
  - jmp with in=1, per=1, adv held high → tc=1 on every cycle.
  - jmp with in=63 → exactly 63 adv pulses to tc.
  - With SSDOWN_BORROW_OUT_EN defined, bo=1 in exactly the cycle before each tc.
